// File: rtl/axi4_lite_pkg.sv
// Shared types and widths for the AXI4-Lite register slave.
package axi4_lite_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axil_resp_e;

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle with master/slave views.
interface axi4_lite_slave_if
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = AXIL_DATA_W
);

    logic [ADDR_WIDTH-1:0]   S_AWADDR;
    logic                    S_AWVALID;
    logic                    S_AWREADY;
    logic [DATA_WIDTH-1:0]   S_WDATA;
    logic [DATA_WIDTH/8-1:0] S_WSTRB;
    logic                    S_WVALID;
    logic                    S_WREADY;
    axil_resp_e              S_BRESP;
    logic                    S_BVALID;
    logic                    S_BREADY;
    logic [ADDR_WIDTH-1:0]   S_ARADDR;
    logic                    S_ARVALID;
    logic                    S_ARREADY;
    logic [DATA_WIDTH-1:0]   S_RDATA;
    axil_resp_e              S_RRESP;
    logic                    S_RVALID;
    logic                    S_RREADY;

    modport slave (
        input  S_AWADDR, S_AWVALID, output S_AWREADY,
        input  S_WDATA, S_WSTRB, S_WVALID, output S_WREADY,
        output S_BRESP, S_BVALID, input S_BREADY,
        input  S_ARADDR, S_ARVALID, output S_ARREADY,
        output S_RDATA, S_RRESP, S_RVALID, input S_RREADY
    );

    modport master (
        output S_AWADDR, S_AWVALID, input S_AWREADY,
        output S_WDATA, S_WSTRB, S_WVALID, input S_WREADY,
        input  S_BRESP, S_BVALID, output S_BREADY,
        output S_ARADDR, S_ARVALID, input S_ARREADY,
        input  S_RDATA, S_RRESP, S_RVALID, output S_RREADY
    );

endinterface

// File: rtl/axil_regfile.sv
// NUM_REGS x 32-bit register bank: byte-enabled write port, combinational read port.
module axil_regfile
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = 16
)
(
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
    input  logic [AXIL_DATA_W-1:0]      wr_data,
    input  logic [AXIL_STRB_W-1:0]      wr_strb,
    input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
    output logic [AXIL_DATA_W-1:0]      rd_data
);

    logic [AXIL_DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < AXIL_STRB_W; k++) begin
                if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // Read is taken before any same-edge write lands, so a colliding read sees the old value.
    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave over a register bank; one outstanding transaction per direction.
// Optional AXIL_ADDR_CHECK_EN: out-of-range addresses answer SLVERR instead of aliasing.
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 16
)
(
    input  logic               ACLK,
    input  logic               ARESETN,
    axi4_lite_slave_if.slave   s_axi
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic                   aw_cap;
    logic                   w_cap;
    logic                   aw_err;
    logic [IDX_W-1:0]       aw_idx;
    logic [AXIL_DATA_W-1:0] w_data;
    logic [AXIL_STRB_W-1:0] w_strb;
    logic                   commit;
    logic                   wr_en;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   aw_oor;
    logic                   ar_oor;
    logic [IDX_W-1:0]       ar_idx;
    logic [AXIL_DATA_W-1:0] rf_rdata;
    logic                   unused_addr_bits;

    assign aw_hs  = s_axi.S_AWVALID && s_axi.S_AWREADY;
    assign w_hs   = s_axi.S_WVALID  && s_axi.S_WREADY;
    assign ar_hs  = s_axi.S_ARVALID && s_axi.S_ARREADY;
    assign ar_idx = s_axi.S_ARADDR[IDX_W+1:2];
    assign commit = aw_cap && w_cap;
    assign wr_en  = commit && !aw_err;

`ifdef AXIL_ADDR_CHECK_EN
    assign aw_oor = |s_axi.S_AWADDR[ADDR_WIDTH-1:IDX_W+2];
    assign ar_oor = |s_axi.S_ARADDR[ADDR_WIDTH-1:IDX_W+2];
    assign unused_addr_bits = ^{s_axi.S_AWADDR[1:0], s_axi.S_ARADDR[1:0]};
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
    assign unused_addr_bits = ^{s_axi.S_AWADDR[ADDR_WIDTH-1:IDX_W+2], s_axi.S_AWADDR[1:0],
                                s_axi.S_ARADDR[ADDR_WIDTH-1:IDX_W+2], s_axi.S_ARADDR[1:0]};
`endif

    axil_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .wr_en   (wr_en),
        .wr_idx  (aw_idx),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .rd_idx  (ar_idx),
        .rd_data (rf_rdata)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi.S_AWREADY <= 1'b0;
            s_axi.S_WREADY  <= 1'b0;
            s_axi.S_BVALID  <= 1'b0;
            s_axi.S_BRESP   <= OKAY;
            s_axi.S_ARREADY <= 1'b0;
            s_axi.S_RVALID  <= 1'b0;
            s_axi.S_RDATA   <= '0;
            s_axi.S_RRESP   <= OKAY;
            aw_cap          <= 1'b0;
            w_cap           <= 1'b0;
            aw_err          <= 1'b0;
            aw_idx          <= '0;
            w_data          <= '0;
            w_strb          <= '0;
        end else begin
            // Ready is a single-cycle pulse; it cannot re-arm while a capture or response is pending.
            s_axi.S_AWREADY <= s_axi.S_AWVALID && !aw_cap && !s_axi.S_BVALID && !s_axi.S_AWREADY;
            s_axi.S_WREADY  <= s_axi.S_WVALID  && !w_cap  && !s_axi.S_BVALID && !s_axi.S_WREADY;
            s_axi.S_ARREADY <= s_axi.S_ARVALID && !s_axi.S_RVALID && !s_axi.S_ARREADY;

            if (aw_hs) begin
                aw_cap <= 1'b1;
                aw_idx <= s_axi.S_AWADDR[IDX_W+1:2];
                aw_err <= aw_oor;
            end
            if (w_hs) begin
                w_cap  <= 1'b1;
                w_data <= s_axi.S_WDATA;
                w_strb <= s_axi.S_WSTRB;
            end

            if (commit) begin
                aw_cap         <= 1'b0;
                w_cap          <= 1'b0;
                s_axi.S_BVALID <= 1'b1;
                s_axi.S_BRESP  <= aw_err ? SLVERR : OKAY;
            end else if (s_axi.S_BVALID && s_axi.S_BREADY) begin
                s_axi.S_BVALID <= 1'b0;
            end

            if (ar_hs) begin
                s_axi.S_RVALID <= 1'b1;
                s_axi.S_RDATA  <= ar_oor ? '0 : rf_rdata;
                s_axi.S_RRESP  <= ar_oor ? SLVERR : OKAY;
            end else if (s_axi.S_RVALID && s_axi.S_RREADY) begin
                s_axi.S_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Self-checking bench for axi4_lite_slave: vector table, corner sequences, random traffic vs a reference model.
module tb_axi4_lite_slave;
    import axi4_lite_pkg::*;

    localparam int NREGS = 16;
`ifdef AXIL_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic ACLK;
    logic ARESETN;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] ref_regs [NREGS];

    axi4_lite_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_slave #(.ADDR_WIDTH(32), .NUM_REGS(NREGS)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .s_axi   (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          order;
        logic [31:0] raddr;
        logic [31:0] rexp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_oor(input logic [31:0] a);
        return ADDR_CHECK && (a >= NREGS * 4);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (model_oor(a)) return;
        idx = (a / 4) % NREGS;
        for (int k = 0; k < 4; k++)
            if (s[k]) ref_regs[idx][8*k +: 8] = d[8*k +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (model_oor(a)) return 32'h0;
        return ref_regs[(a / 4) % NREGS];
    endfunction

    // order: 0 = AW then W, 1 = W then AW, 2 = both together
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int order, input int bhold, input logic [1:0] exp_resp,
                            input string name);
        bit aw_done, w_done, aw_fire, w_fire, got_b;
        aw_done = 0; w_done = 0; got_b = 0;
        @(posedge ACLK); #1;
        bus.S_AWADDR = a; bus.S_WDATA = d; bus.S_WSTRB = s;
        if (order != 1) bus.S_AWVALID = 1'b1;
        if (order != 0) bus.S_WVALID = 1'b1;
        for (int c = 0; c < 32 && !(aw_done && w_done); c++) begin
            @(negedge ACLK);
            aw_fire = bus.S_AWVALID && bus.S_AWREADY;
            w_fire  = bus.S_WVALID && bus.S_WREADY;
            @(posedge ACLK); #1;
            if (aw_fire) begin
                bus.S_AWVALID = 1'b0; aw_done = 1;
                if (!w_done && !bus.S_WVALID) bus.S_WVALID = 1'b1;
            end
            if (w_fire) begin
                bus.S_WVALID = 1'b0; w_done = 1;
                if (!aw_done && !bus.S_AWVALID) bus.S_AWVALID = 1'b1;
            end
        end
        chk({name, "_aw_w_accepted"}, {30'd0, aw_done, w_done}, 32'd3);
        bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
        for (int c = 0; c < 16 && !got_b; c++) begin
            @(negedge ACLK);
            got_b = bus.S_BVALID;
        end
        chk({name, "_bvalid_seen"}, got_b, 1);
        chk({name, "_bresp"}, bus.S_BRESP, exp_resp);
        if (bhold > 0) begin
            bus.S_AWADDR = 32'h14; bus.S_AWVALID = 1'b1;
            for (int i = 0; i < bhold; i++) begin
                @(negedge ACLK);
                chk({name, "_bhold_bvalid"}, bus.S_BVALID, 1);
                chk({name, "_bhold_bresp"}, bus.S_BRESP, exp_resp);
                chk({name, "_bhold_awready"}, bus.S_AWREADY, 0);
            end
            bus.S_AWVALID = 1'b0;
        end
        bus.S_BREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.S_BREADY = 1'b0;
        @(negedge ACLK);
        chk({name, "_bvalid_drop"}, bus.S_BVALID, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input int rhold, input string name);
        bit fired, ar_fire, got_r;
        fired = 0; got_r = 0;
        @(posedge ACLK); #1;
        bus.S_ARADDR = a; bus.S_ARVALID = 1'b1;
        for (int c = 0; c < 32 && !fired; c++) begin
            @(negedge ACLK);
            ar_fire = bus.S_ARVALID && bus.S_ARREADY;
            @(posedge ACLK); #1;
            if (ar_fire) begin
                bus.S_ARVALID = 1'b0; fired = 1;
            end
        end
        chk({name, "_ar_accepted"}, fired, 1);
        bus.S_ARVALID = 1'b0;
        for (int c = 0; c < 16 && !got_r; c++) begin
            @(negedge ACLK);
            got_r = bus.S_RVALID;
        end
        chk({name, "_rvalid_seen"}, got_r, 1);
        chk({name, "_rdata"}, bus.S_RDATA, exp_d);
        chk({name, "_rresp"}, bus.S_RRESP, exp_r);
        for (int i = 0; i < rhold; i++) begin
            @(negedge ACLK);
            chk({name, "_rhold_rvalid"}, bus.S_RVALID, 1);
            chk({name, "_rhold_rdata"}, bus.S_RDATA, exp_d);
        end
        bus.S_RREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.S_RREADY = 1'b0;
        @(negedge ACLK);
        chk({name, "_rvalid_drop"}, bus.S_RVALID, 0);
    endtask

    initial begin
        logic [31:0] a, d, exp_d;
        logic [3:0]  s;
        logic [1:0]  exp_r;

        vecs[0] = '{32'h04, 32'hDEADBEEF, 4'hF, 0, 32'h04, 32'hDEADBEEF};
        vecs[1] = '{32'h08, 32'h11111111, 4'hF, 1, 32'h08, 32'h11111111};
        vecs[2] = '{32'h08, 32'hCAFEF00D, 4'hF, 2, 32'h08, 32'hCAFEF00D};
        vecs[3] = '{32'h0C, 32'h11223344, 4'hF, 2, 32'h0C, 32'h11223344};
        vecs[4] = '{32'h0C, 32'hAABBCCDD, 4'h5, 0, 32'h0C, 32'h11BB33DD};
        vecs[5] = '{32'h3C, 32'hFFFF0000, 4'hC, 1, 32'h3C, 32'hFFFF0000};
        vecs[6] = '{32'h05, 32'h12345678, 4'hF, 0, 32'h07, 32'h12345678};

        for (int i = 0; i < NREGS; i++) ref_regs[i] = 32'h0;

        bus.S_AWADDR = '0; bus.S_AWVALID = 0; bus.S_WDATA = '0; bus.S_WSTRB = '0;
        bus.S_WVALID = 0; bus.S_BREADY = 0; bus.S_ARADDR = '0; bus.S_ARVALID = 0;
        bus.S_RREADY = 0;

        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", bus.S_AWREADY, 0);
        chk("rst_wready",  bus.S_WREADY, 0);
        chk("rst_bvalid",  bus.S_BVALID, 0);
        chk("rst_arready", bus.S_ARREADY, 0);
        chk("rst_rvalid",  bus.S_RVALID, 0);
        chk("rst_bresp",   bus.S_BRESP, OKAY);
        chk("rst_rresp",   bus.S_RRESP, OKAY);
        chk("rst_rdata",   bus.S_RDATA, 0);
        ARESETN = 1'b1;
        do_read(32'h0, 32'h0, OKAY, 0, "rst_read0");

        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].order, 0, OKAY,
                     $sformatf("vec%0d_wr", i));
            model_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
            do_read(vecs[i].raddr, vecs[i].rexp, OKAY, 0, $sformatf("vec%0d_rd", i));
        end

        // Backpressure on both response channels
        do_write(32'h10, 32'h5A5A5A5A, 4'hF, 0, 5, OKAY, "bp_wr");
        model_write(32'h10, 32'h5A5A5A5A, 4'hF);
        do_read(32'h14, 32'h0, OKAY, 0, "bp_no_stray_aw");
        do_read(32'h10, 32'h5A5A5A5A, OKAY, 5, "bp_rd");

        // Read and write commit on the same edge: read returns the old value
        do_write(32'h20, 32'h01010101, 4'hF, 2, 0, OKAY, "coll_pre");
        model_write(32'h20, 32'h01010101, 4'hF);
        fork
            do_write(32'h20, 32'h02020202, 4'hF, 2, 0, OKAY, "coll_wr");
            begin
                @(posedge ACLK);
                do_read(32'h20, 32'h01010101, OKAY, 0, "coll_rd");
            end
        join
        model_write(32'h20, 32'h02020202, 4'hF);
        do_read(32'h20, 32'h02020202, OKAY, 0, "coll_after");

`ifdef AXIL_ADDR_CHECK_EN
        do_write(32'h100, 32'h77777777, 4'hF, 2, 0, SLVERR, "oor_wr");
        do_read(32'h100, 32'h0, SLVERR, 0, "oor_rd");
        do_read(32'h00, 32'h0, OKAY, 0, "oor_reg0_untouched");
        do_read(32'h04, model_read(32'h04), OKAY, 0, "oor_reg1_untouched");
`else
        do_write(32'h104, 32'h76543210, 4'hF, 0, 0, OKAY, "alias_wr");
        model_write(32'h104, 32'h76543210, 4'hF);
        do_read(32'h04, 32'h76543210, OKAY, 0, "alias_rd");
`endif

        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                exp_r = model_oor(a) ? SLVERR : OKAY;
                do_write(a, d, s, int'($urandom_range(0, 2)), 0, exp_r, $sformatf("rnd%0d_wr", n));
                model_write(a, d, s);
            end else begin
                exp_d = model_read(a);
                exp_r = model_oor(a) ? SLVERR : OKAY;
                do_read(a, exp_d, exp_r, 0, $sformatf("rnd%0d_rd", n));
            end
        end

        // Reset while a write response is pending
        @(posedge ACLK); #1;
        bus.S_AWADDR = 32'h08; bus.S_WDATA = 32'h99999999; bus.S_WSTRB = 4'hF;
        bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1;
        repeat (5) @(negedge ACLK);
        chk("abort_bvalid_before", bus.S_BVALID, 1);
        bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
        ARESETN = 1'b0;
        #1;
        chk("abort_bvalid", bus.S_BVALID, 0);
        chk("abort_awready", bus.S_AWREADY, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < NREGS; i++) ref_regs[i] = 32'h0;
        do_read(32'h08, 32'h0, OKAY, 0, "abort_reg2");
        do_read(32'h04, 32'h0, OKAY, 0, "abort_reg1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
